// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write-port arbiter: FSM state encodings,
// requester IDs and the starvation counter width.
package rf_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } arb_state_e;

    localparam int REQ_WB  = 0;
    localparam int REQ_MDU = 1;
    localparam int REQ_DBG = 2;
    localparam int NUM_REQ = 3;

    // MAX_WAIT tops out at 15, so four bits always suffice
    localparam int CNT_W = 4;

endpackage

// File: rtl/rf_arb_starve_ctr.sv
// MDU starvation counter: clears, increments while blocked, and flags the
// terminal count at MAX_WAIT. Holds whenever the global clock enable is low.
module rf_arb_starve_ctr
    import rf_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_tc
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_en) begin
            if (i_clr)
                cnt_d = '0;
            else if (i_inc && cnt_q != CNT_W'(MAX_WAIT))
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign o_tc = (cnt_q == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter (WB > MDU > DBG) with an anti-starvation FSM
// that stalls WB for one slot. Define RF_ARB_PERF_EN to add perf counters.
module rf_wr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int XLEN     = 32,
    parameter int AW       = 5
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clk_enable,
    input  logic            i_wb_we,
    input  logic [AW-1:0]   i_wb_addr,
    input  logic [XLEN-1:0] i_wb_data,
    input  logic            i_mdu_valid,
    input  logic [AW-1:0]   i_mdu_addr,
    input  logic [XLEN-1:0] i_mdu_data,
    output logic            o_mdu_ready,
    input  logic            i_dbg_halted,
    input  logic            i_dbg_we,
    input  logic [AW-1:0]   i_dbg_addr,
    input  logic [XLEN-1:0] i_dbg_data,
    output logic            o_dbg_ack,
    output logic            o_stall_wb,
    output logic            o_rf_we,
    output logic [AW-1:0]   o_rf_addr,
    output logic [XLEN-1:0] o_rf_data
`ifdef RF_ARB_PERF_EN
    ,
    output logic [31:0]     o_perf_mdu_wait,
    output logic [31:0]     o_perf_force
`endif
);

    arb_state_e          state_q, state_d;
    logic                stall_q, stall_d;
    logic                rf_we_q, rf_we_d;
    logic [AW-1:0]       rf_addr_q, rf_addr_d;
    logic [XLEN-1:0]     rf_data_q, rf_data_d;

    logic                en, in_force;
    logic                wb_req, mdu_req, dbg_req;
    logic                wb_gnt, mdu_gnt, dbg_gnt;
    logic                ctr_clr, ctr_inc, ctr_tc;
    logic [NUM_REQ-1:0]  gnt_vec;

    assign en       = i_clk_enable && !i_rst;
    assign in_force = (state_q == ST_FORCE);

    // A WB write to x0 never claims the port, leaving the slot to MDU/DBG
    assign wb_req  = i_wb_we && (i_wb_addr != '0) && !stall_q;
    assign mdu_req = i_mdu_valid;
    assign dbg_req = i_dbg_we && i_dbg_halted;

    always_comb begin
        wb_gnt  = 1'b0;
        mdu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (en) begin
            if (in_force)     mdu_gnt = mdu_req;
            else if (wb_req)  wb_gnt  = 1'b1;
            else if (mdu_req) mdu_gnt = 1'b1;
            else if (dbg_req) dbg_gnt = 1'b1;
        end
    end

    assign o_mdu_ready = en && (in_force || !wb_req);
    assign o_dbg_ack   = dbg_gnt;

    always_comb begin
        gnt_vec          = '0;
        gnt_vec[REQ_WB]  = wb_gnt;
        gnt_vec[REQ_MDU] = mdu_gnt;
        gnt_vec[REQ_DBG] = dbg_gnt;
    end

    always_comb begin
        state_d = state_q;
        stall_d = stall_q;
        ctr_clr = 1'b0;
        ctr_inc = 1'b0;
        if (i_clk_enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (mdu_req && wb_req) begin
                        state_d = ST_WAIT;
                        ctr_inc = 1'b1;
                    end
                end
                ST_WAIT: begin
                    // Dropped valid is a protocol violation; recover to IDLE
                    if (!mdu_req || mdu_gnt) begin
                        state_d = ST_IDLE;
                        ctr_clr = 1'b1;
                    end else if (ctr_tc) begin
                        state_d = ST_FORCE;
                        stall_d = 1'b1;
                    end else begin
                        ctr_inc = 1'b1;
                    end
                end
                ST_FORCE: begin
                    if (!mdu_req || mdu_gnt) begin
                        state_d = ST_IDLE;
                        stall_d = 1'b0;
                        ctr_clr = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    stall_d = 1'b0;
                    ctr_clr = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        if (wb_gnt) begin
            rf_we_d   = 1'b1;
            rf_addr_d = i_wb_addr;
            rf_data_d = i_wb_data;
        end else if (mdu_gnt) begin
            rf_we_d   = (i_mdu_addr != '0);
            rf_addr_d = i_mdu_addr;
            rf_data_d = i_mdu_data;
        end else if (dbg_gnt) begin
            rf_we_d   = (i_dbg_addr != '0);
            rf_addr_d = i_dbg_addr;
            rf_data_d = i_dbg_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            stall_q   <= 1'b0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else if (i_clk_enable) begin
            state_q   <= state_d;
            stall_q   <= stall_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert ($onehot0(gnt_vec));
            assert (stall_q == in_force);
        end
    end

    rf_arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_ctr (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (i_clk_enable),
        .i_clr (ctr_clr),
        .i_inc (ctr_inc),
        .o_tc  (ctr_tc)
    );

    assign o_stall_wb = stall_q;
    assign o_rf_we    = rf_we_q;
    assign o_rf_addr  = rf_addr_q;
    assign o_rf_data  = rf_data_q;

`ifdef RF_ARB_PERF_EN
    logic [31:0] perf_wait_q, perf_wait_d;
    logic [31:0] perf_force_q, perf_force_d;

    always_comb begin
        perf_wait_d  = perf_wait_q;
        perf_force_d = perf_force_q;
        if (i_clk_enable) begin
            if ((state_q == ST_WAIT || state_q == ST_FORCE) && mdu_req && perf_wait_q != '1)
                perf_wait_d = perf_wait_q + 32'd1;
            if (state_q == ST_WAIT && state_d == ST_FORCE && perf_force_q != '1)
                perf_force_d = perf_force_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            perf_wait_q  <= '0;
            perf_force_q <= '0;
        end else begin
            perf_wait_q  <= perf_wait_d;
            perf_force_q <= perf_force_d;
        end
    end

    assign o_perf_mdu_wait = perf_wait_q;
    assign o_perf_force    = perf_force_q;
`endif

endmodule
